// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, two write ports, reservation and status outputs.
interface regfile_sb_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned CW = $clog2(NREGS + 1);

    logic [NRD*AW-1:0]   RADDR;
    logic [NRD*XLEN-1:0] RDATA;
    logic [NRD-1:0]      RBUSY;
    logic                WA_EN;
    logic [AW-1:0]       WA_ADDR;
    logic [XLEN-1:0]     WA_DATA;
    logic                WB_EN;
    logic [AW-1:0]       WB_ADDR;
    logic [XLEN-1:0]     WB_DATA;
    logic                RSV_EN;
    logic [AW-1:0]       RSV_ADDR;
    logic [CW-1:0]       PEND_CNT;
    logic                WB_ERR;

    modport master (
        output RADDR, WA_EN, WA_ADDR, WA_DATA, WB_EN, WB_ADDR, WB_DATA, RSV_EN, RSV_ADDR,
        input  RDATA, RBUSY, PEND_CNT, WB_ERR
    );

    modport slave (
        input  RADDR, WA_EN, WA_ADDR, WA_DATA, WB_EN, WB_ADDR, WB_DATA, RSV_EN, RSV_ADDR,
        output RDATA, RBUSY, PEND_CNT, WB_ERR
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with NRD bypassed read ports, two write ports (A has priority)
// and a per-register pending scoreboard for decode-stage operand hazard detection.
module regfile_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic          CLK,
    input logic          RST_N,
    regfile_sb_if.slave  bus
);
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned CW = $clog2(NREGS + 1);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             wb_pend;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NREGS;
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    always_comb begin
        regs_d  = regs_q;
        pend_d  = pend_q;
        cnt_d   = '0;
        wb_pend = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (!(ZERO_REG && r == 0)) begin
                if (bus.WA_EN && bus.WA_ADDR == AW'(r)) begin
                    regs_d[r] = bus.WA_DATA;
                end else if (bus.WB_EN && bus.WB_ADDR == AW'(r)) begin
                    regs_d[r] = bus.WB_DATA;
                end
                // A same-cycle reservation belongs to a younger instruction, so it wins.
                if (bus.RSV_EN && bus.RSV_ADDR == AW'(r)) begin
                    pend_d[r] = 1'b1;
                end else if (bus.WB_EN && bus.WB_ADDR == AW'(r)) begin
                    pend_d[r] = 1'b0;
                end
            end
            if (bus.WB_ADDR == AW'(r)) begin
                wb_pend = pend_q[r];
            end
        end
        for (int r = 0; r < NREGS; r++) begin
            cnt_d = cnt_d + CW'(pend_d[r]);
        end
        err_d = bus.WB_EN && in_range(bus.WB_ADDR) && !is_zero(bus.WB_ADDR) && !wb_pend;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            regs_q <= '{default: '0};
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign bus.PEND_CNT = cnt_q;
    assign bus.WB_ERR   = err_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] stored, rdata;
        logic            pend, rbusy;

        assign ra = bus.RADDR[k*AW +: AW];

        always_comb begin
            stored = '0;
            pend   = 1'b0;
            for (int r = 0; r < NREGS; r++) begin
                if (ra == AW'(r)) begin
                    stored = regs_q[r];
                    pend   = pend_q[r];
                end
            end
        end

        always_comb begin
            rdata = '0;
            rbusy = 1'b0;
            if (!is_zero(ra) && in_range(ra)) begin
                if (bus.WA_EN && bus.WA_ADDR == ra) begin
                    rdata = bus.WA_DATA;
                end else if (bus.WB_EN && bus.WB_ADDR == ra) begin
                    rdata = bus.WB_DATA;
                end else begin
                    rdata = stored;
                end
                rbusy = pend && !(bus.WB_EN && bus.WB_ADDR == ra);
            end
        end

        assign bus.RDATA[k*XLEN +: XLEN] = rdata;
        assign bus.RBUSY[k]              = rbusy;
    end

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            assert ($countones(pend_q) == 32'(cnt_q))
                else $error("pending count out of step with pending vector");
        end
    end
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven check of regfile_sb: bypass reads, write priority, scoreboard, WB_ERR.
module tb_regfile_sb;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    typedef struct {
        logic        wa_en;
        logic [4:0]  wa_addr;
        logic [31:0] wa_data;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        rsv_en;
        logic [4:0]  rsv_addr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_busy;
        logic [5:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input int wa_en, input int wa_addr, input logic [31:0] wa_data,
                                input int wb_en, input int wb_addr, input logic [31:0] wb_data,
                                input int rsv_en, input int rsv_addr, input int ra0, input int ra1,
                                input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                                input int e_busy, input int e_cnt, input int e_err);
        vec_t v;
        v.wa_en = 1'(wa_en);   v.wa_addr = 5'(wa_addr);   v.wa_data = wa_data;
        v.wb_en = 1'(wb_en);   v.wb_addr = 5'(wb_addr);   v.wb_data = wb_data;
        v.rsv_en = 1'(rsv_en); v.rsv_addr = 5'(rsv_addr);
        v.ra0 = 5'(ra0);       v.ra1 = 5'(ra1);
        v.e_rd0 = e_rd0;       v.e_rd1 = e_rd1;
        v.e_busy = 2'(e_busy); v.e_cnt = 6'(e_cnt);       v.e_err = 1'(e_err);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.WA_EN = 1'b0; bus.WA_ADDR = '0; bus.WA_DATA = '0;
        bus.WB_EN = 1'b0; bus.WB_ADDR = '0; bus.WB_DATA = '0;
        bus.RSV_EN = 1'b0; bus.RSV_ADDR = '0;
    endtask

    task automatic drive(input vec_t v);
        bus.WA_EN = v.wa_en;   bus.WA_ADDR = v.wa_addr;   bus.WA_DATA = v.wa_data;
        bus.WB_EN = v.wb_en;   bus.WB_ADDR = v.wb_addr;   bus.WB_DATA = v.wb_data;
        bus.RSV_EN = v.rsv_en; bus.RSV_ADDR = v.rsv_addr;
        bus.RADDR = {v.ra1, v.ra0};
    endtask

    initial begin
        // Each row: inputs held for one cycle; outputs checked before the edge that commits them.
        vecs[0]  = mk(1, 3, 32'h12345678, 0, 0, 0, 0, 0, 3, 0, 32'h12345678, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 3, 0, 32'h12345678, 0, 0, 0, 0);
        vecs[2]  = mk(1, 7, 32'hAAAA0000, 1, 7, 32'h5555FFFF, 0, 0, 7, 7,
                      32'hAAAA0000, 32'hAAAA0000, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1, 9, 7, 9, 32'hAAAA0000, 0, 0, 0, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 1, 0);
        vecs[5]  = mk(0, 0, 0, 1, 9, 32'h42, 0, 0, 9, 9, 32'h42, 32'h42, 0, 1, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 4, 32'h42, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 4, 4, 9, 0, 32'h42, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 1, 4, 32'h44, 1, 4, 4, 1, 32'h44, 0, 0, 1, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 32'h44, 0, 1, 1, 0);
        vecs[10] = mk(0, 0, 0, 1, 6, 32'h66, 0, 0, 6, 4, 32'h66, 32'h44, 2, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 4, 32'h66, 32'h44, 2, 1, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 32'h66, 0, 0, 1, 0);
        vecs[13] = mk(0, 0, 0, 1, 4, 32'h4444, 0, 0, 4, 4, 32'h4444, 32'h4444, 0, 1, 0);
        vecs[14] = mk(0, 0, 0, 1, 0, 32'h1, 0, 0, 0, 4, 0, 32'h4444, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 32'hAAAA0000, 0, 0, 0);

        idle();
        bus.RADDR = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < NREGS; i += 2) begin
            bus.RADDR = {5'(i + 1), 5'(i)};
            #1;
            check($sformatf("reset_rd x%0d", i), bus.RDATA[31:0], 0);
            check($sformatf("reset_rd x%0d", i + 1), bus.RDATA[63:32], 0);
            check($sformatf("reset_busy x%0d", i), 32'(bus.RBUSY), 0);
        end
        check("reset_cnt", 32'(bus.PEND_CNT), 0);
        check("reset_err", 32'(bus.WB_ERR), 0);

        // Reset dropped while a write to x5 is still being driven.
        @(negedge CLK);
        bus.WA_EN = 1'b1; bus.WA_ADDR = 5'd5; bus.WA_DATA = 32'hDEADBEEF;
        bus.RADDR = {5'd0, 5'd5};
        @(posedge CLK);
        #1;
        check("x5_written", bus.RDATA[31:0], 32'hDEADBEEF);
        #1 RST_N = 1'b0;
        #1 idle();
        #1 check("x5_in_reset", bus.RDATA[31:0], 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1 check("x5_after_reset", bus.RDATA[31:0], 0);

        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_rd0", i), bus.RDATA[31:0], vecs[i].e_rd0);
            check($sformatf("v%0d_rd1", i), bus.RDATA[63:32], vecs[i].e_rd1);
            check($sformatf("v%0d_busy", i), 32'(bus.RBUSY), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_cnt", i), 32'(bus.PEND_CNT), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_err", i), 32'(bus.WB_ERR), 32'(vecs[i].e_err));
        end

        // Reserve every address including x0; only x1..x31 can become pending.
        for (int r = 0; r < NREGS; r++) begin
            @(negedge CLK);
            idle();
            bus.RSV_EN = 1'b1; bus.RSV_ADDR = 5'(r);
        end
        @(negedge CLK);
        bus.RSV_ADDR = 5'd5;
        #1 check("all_cnt", 32'(bus.PEND_CNT), 31);
        @(negedge CLK);
        idle();
        bus.RADDR = {5'd31, 5'd0};
        #1;
        check("rersv_cnt", 32'(bus.PEND_CNT), 31);
        check("all_busy", 32'(bus.RBUSY), 2);
        check("all_err", 32'(bus.WB_ERR), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
